// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//
// Write-back queue between the execute stage and the register file write
// port. Completed results are buffered in a small circular buffer and are
// drained into the register file one per cycle, in acceptance order,
// through a registered output stage (we/waddr/wdata). An optional bypass
// lookup lets read ports see values that are still pending.
//
// Build option:
//   REGFILE_WBQ_BYPASS_EN  defined   -> bypass lookup logic present
//                          undefined -> byp_hit_* / byp_data_* tied to 0,
//                                       lk_addr_* ignored
//
// Ports:
//   clk                     clock, rising edge
//   rst_s                   asynchronous active-high reset
//   in_valid/in_ready       execute-side handshake (in_ready = !full)
//   in_addr/in_data         destination register and result value
//   wr_stall                register file write port busy this cycle
//   we/waddr/wdata          registered register file write port
//   lk_addr_1/lk_addr_2     bypass lookup addresses
//   byp_hit_*/byp_data_*    pending-write hit and youngest pending value
//   count                   entries held in the queue (output stage excluded)

module regfile_wb_queue #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 6,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_s,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wr_stall,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] lk_addr_1,
    input  logic [ADDR_W-1:0] lk_addr_2,
    output logic              byp_hit_1,
    output logic              byp_hit_2,
    output logic [DATA_W-1:0] byp_data_1,
    output logic [DATA_W-1:0] byp_data_2,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;

    // Ready depends only on the current occupancy, so a full queue refuses
    // a push even in a cycle where it also pops.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !wr_stall;

    // Entry storage needs no reset: count gates which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail] <= in_addr;
            mem_data[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A push into an empty queue is never forwarded straight to the
            // output stage; it always spends at least one cycle queued.
            we <= pop;
            if (pop) begin
                waddr <= mem_addr[head];
                wdata <= mem_data[head];
            end
        end
    end

`ifdef REGFILE_WBQ_BYPASS_EN
    logic [PTR_W-1:0] idx;

    // Search oldest to youngest (output stage, then queue from head) so the
    // last match found is the youngest pending value.
    always_comb begin
        byp_hit_1  = 1'b0;
        byp_hit_2  = 1'b0;
        byp_data_1 = '0;
        byp_data_2 = '0;
        idx        = '0;
        if (we && (waddr == lk_addr_1)) begin
            byp_hit_1  = 1'b1;
            byp_data_1 = wdata;
        end
        if (we && (waddr == lk_addr_2)) begin
            byp_hit_2  = 1'b1;
            byp_data_2 = wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                idx = head + PTR_W'(i);
                if (mem_addr[idx] == lk_addr_1) begin
                    byp_hit_1  = 1'b1;
                    byp_data_1 = mem_data[idx];
                end
                if (mem_addr[idx] == lk_addr_2) begin
                    byp_hit_2  = 1'b1;
                    byp_data_2 = mem_data[idx];
                end
            end
        end
    end
`else
    logic unused_lk;

    assign unused_lk  = ^{lk_addr_1, lk_addr_2};
    assign byp_hit_1  = 1'b0;
    assign byp_hit_2  = 1'b0;
    assign byp_data_1 = '0;
    assign byp_data_2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_s = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        wr_stall = 1'b0;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  lk_addr_1 = '0;
    logic [5:0]  lk_addr_2 = '0;
    logic        byp_hit_1, byp_hit_2;
    logic [31:0] byp_data_1, byp_data_2;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    regfile_wb_queue #(.DATA_W(32), .ADDR_W(6), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_s(rst_s),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .wr_stall(wr_stall),
        .we(we), .waddr(waddr), .wdata(wdata),
        .lk_addr_1(lk_addr_1), .lk_addr_2(lk_addr_2),
        .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
        .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes as an ordered list plus the write
    // currently presented to the register file.
    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [5:0]  m_waddr;
    logic [31:0] m_wdata;
    ent_t        issued[$];

    logic [42:0] dut_vec;
    logic [65:0] dut_byp;
    assign dut_vec = {we, waddr, wdata, count, in_ready};
    assign dut_byp = {byp_hit_1, byp_data_1, byp_hit_2, byp_data_2};

    function automatic logic [42:0] exp_vec();
        return {m_we, m_waddr, m_wdata, 3'(mq.size()), mq.size() != DEPTH};
    endfunction

    function automatic void model_byp(input logic [5:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
`ifdef REGFILE_WBQ_BYPASS_EN
        if (m_we && m_waddr == a) begin
            h = 1'b1;
            d = m_wdata;
        end
        foreach (mq[i]) begin
            if (mq[i].a == a) begin
                h = 1'b1;
                d = mq[i].d;
            end
        end
`endif
    endfunction

    function automatic logic [65:0] exp_byp();
        logic        h1, h2;
        logic [31:0] d1, d2;
        model_byp(lk_addr_1, h1, d1);
        model_byp(lk_addr_2, h2, d2);
        return {h1, d1, h2, d2};
    endfunction

    // Advance one clock; the model applies the rules to the inputs held
    // across the edge. Returns at the following falling edge.
    task automatic tick();
        bit do_push, do_pop;
        @(posedge clk);
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() != 0) && !wr_stall;
        if (do_pop) begin
            ent_t e;
            e = mq.pop_front();
            m_we = 1'b1;
            m_waddr = e.a;
            m_wdata = e.d;
            issued.push_back(e);
        end else begin
            m_we = 1'b0;
        end
        if (do_push) mq.push_back('{a: in_addr, d: in_data});
        @(negedge clk);
    endtask

    task automatic model_clear();
        mq.delete();
        issued.delete();
        m_we = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_s = 1'b1;
        in_valid = 1'b0;
        wr_stall = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_s = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++;
        if (dut_vec !== exp_vec() || dut_vec !== {1'b0, 6'd0, 32'd0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", dut_vec, exp_vec());
        end
        total++;
        if (byp_hit_1 !== 1'b0 || byp_hit_2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_byp got=%b%b want=00", byp_hit_1, byp_hit_2);
        end
    endtask

    task automatic test_single_write();
        in_valid = 1'b1; in_addr = 6'd1; in_data = 32'h1;
        tick();
        in_valid = 1'b0;
        total++;
        if (dut_vec !== exp_vec() || we !== 1'b0 || count !== 3'd1) begin
            bad++;
            $display("FAIL single_queued got=%h want=%h", dut_vec, exp_vec());
        end
        tick();
        total++;
        if (dut_vec !== exp_vec() || {we, waddr, wdata, count} !== {1'b1, 6'd1, 32'h1, 3'd0}) begin
            bad++;
            $display("FAIL single_issue got=%h want=%h", dut_vec, exp_vec());
        end
        tick();
        total++;
        if (dut_vec !== exp_vec() || we !== 1'b0) begin
            bad++;
            $display("FAIL single_done got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fill();
        wr_stall = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            in_valid = 1'b1; in_addr = 6'(i); in_data = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (dut_vec !== exp_vec() || count !== 3'd4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full got=%h want=%h", dut_vec, exp_vec());
        end
        wr_stall = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec() || we !== 1'b1 || waddr !== 6'(i) || wdata !== 32'(i)) begin
                bad++;
                $display("FAIL fill_drain_%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        tick();
        total++;
        if (dut_vec !== exp_vec() || we !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL fill_empty got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_bypass();
        wr_stall = 1'b1;
        in_valid = 1'b1; in_addr = 6'd3; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        lk_addr_1 = 6'd3; lk_addr_2 = 6'd7;
        #1;
        total++;
`ifdef REGFILE_WBQ_BYPASS_EN
        if (dut_byp !== exp_byp() || dut_byp !== {1'b1, 32'hB, 1'b0, 32'h0}) begin
`else
        if (dut_byp !== exp_byp() || dut_byp !== '0) begin
`endif
            bad++;
            $display("FAIL bypass_young got=%h want=%h", dut_byp, exp_byp());
        end
        wr_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            total++;
            if (dut_vec !== exp_vec() || dut_byp !== exp_byp()) begin
                bad++;
                $display("FAIL bypass_drain_%0d got=%h/%h want=%h/%h", i, dut_vec, dut_byp, exp_vec(), exp_byp());
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = issued.size();
        wr_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_addr = 6'(10 + i); in_data = 32'h100 + 32'(i);
            tick();
        end
        wr_stall = 1'b0;
        for (int i = 2; i < 8; i++) begin
            in_addr = 6'(10 + i); in_data = 32'h100 + 32'(i);
            tick();
            total++;
            if (dut_vec !== exp_vec() || count !== 3'd2 || waddr !== 6'(10 + i - 2)) begin
                bad++;
                $display("FAIL b2b_%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (issued.size() - n0 != 8 || we !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL b2b_order got=%0d writes want=8", issued.size() - n0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            wr_stall  = ($urandom_range(0, 2) == 0);
            in_addr   = 6'($urandom_range(0, 7));
            in_data   = $urandom;
            lk_addr_1 = 6'($urandom_range(0, 7));
            lk_addr_2 = 6'($urandom_range(0, 7));
            #1;
            total++;
            if (dut_vec !== exp_vec() || dut_byp !== exp_byp()) begin
                bad++;
                $display("FAIL rand_%0d got=%h/%h want=%h/%h", c, dut_vec, dut_byp, exp_vec(), exp_byp());
            end
            tick();
        end
        in_valid = 1'b0;
        wr_stall = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL rand_drain got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_drain();
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 6'(20 + i); in_data = 32'h200 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        wr_stall = 1'b0;
        tick();
        total++;
        if (dut_vec !== exp_vec() || we !== 1'b1 || count !== 3'd3) begin
            bad++;
            $display("FAIL mid_pre got=%h want=%h", dut_vec, exp_vec());
        end
        #2;
        rst_s = 1'b1;
        model_clear();
        #1;
        total++;
        if (dut_vec !== {1'b0, 6'd0, 32'd0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset got=%h want=%h", dut_vec, {1'b0, 6'd0, 32'd0, 3'd0, 1'b1});
        end
        @(negedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec() || we !== 1'b0) begin
                bad++;
                $display("FAIL mid_after_%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_single_write();
        test_fill();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue sitting between the execute stage and the 64-entry register file write port (we/waddr/wdata). Buffers up to DEPTH completed results and drains them into the register file one per cycle, in order, so execute is never stalled by a busy write port. It also offers a bypass lookup so read ports see pending (not yet written) values. It is the initiator side of the register file write interface.

## Interface
- DATA_W, 32, data width (matches register file word)
- ADDR_W, 6, register address width
- DEPTH, 4, queue entries; power of two, 2..16
- clk  in  1  clock; all state updates on rising edge
- rst_s  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents a result
- in_ready  out  1  queue can accept; = !full (combinational from count)
- in_addr  in  ADDR_W  destination register
- in_data  in  DATA_W  result value
- wr_stall  in  1  register file write port unavailable this cycle
- we  out  1  register file write enable (registered)
- waddr  out  ADDR_W  register file write address (registered)
- wdata  out  DATA_W  register file write data (registered)
- lk_addr_1, lk_addr_2  in  ADDR_W  bypass lookup addresses (driven with raddr_1/raddr_2)
- byp_hit_1, byp_hit_2  out  1  pending write exists for lookup address
- byp_data_1, byp_data_2  out  DATA_W  youngest pending value for that address
- count  out  clog2(DEPTH)+1  entries held in queue (excludes output stage)

## Operation
- Storage: circular buffer, DEPTH entries of {addr,data}; head/tail pointers wrap modulo DEPTH; count tracks occupancy.
- Push: in_valid && in_ready at edge -> entry written at tail, tail++, count++.
- Pop: count != 0 && !wr_stall at edge -> head entry loaded into output stage (we<=1, waddr, wdata), head++, count--.
- Otherwise at edge: we<=0; waddr/wdata hold last value.
- Simultaneous push+pop: both performed, count unchanged. Push when full is refused even if a pop happens that cycle (in_ready depends only on current count).
- Push when empty: entry goes into queue, never bypasses the queue directly to the output stage.
- Ordering: writes reach register file strictly in acceptance order; repeated writes to one address all issue, last one wins.
- Bypass (combinational): for each lookup port, search output stage (if we=1) and all valid queue entries; hit if any address matches; data from youngest match (youngest queue entry, else output stage). No special case for address 0.
- in_valid with in_ready=0: no state change; producer must hold values.

## Timing
- Reset (async assert, sync to edge on release): count=0, head=tail=0, we=0, waddr=0, wdata=0, in_ready=1, byp_hit_*=0. Entries in flight are discarded, including a pending output-stage write.
- Latency: result accepted at edge N; we=1 for it during cycle N+1 at earliest (register file captures it at edge N+2).
- Throughput: one push and one write per cycle sustained.
- wr_stall sampled at edge; stall in cycle N means no new we in cycle N+1; head entry held.
- Full: count=DEPTH -> in_ready=0 in same cycle. Empty: count=0 -> we drops to 0 after the final drained write.

## Configuration
- REGFILE_WBQ_BYPASS_EN defined: bypass lookup logic as described.
- Undefined: lookup logic omitted; byp_hit_*=0 and byp_data_*=0 constantly; lk_addr_* ignored; all other behaviour identical.

## Test plan
- Single write: reset, push {addr 1, data 0x1} at edge 1 -> we=1, waddr=1, wdata=0x1 during cycle 2 only; count returns to 0.
- Fill: wr_stall=1, push addresses 2,3,4,5 data 0x2..0x5 -> count=4, in_ready=0; fifth push ignored; release stall -> four consecutive we pulses in order 2,3,4,5.
- Bypass: stall, push {3,0xA} then {3,0xB}; lk_addr_1=3 -> byp_hit_1=1, byp_data_1=0xB; lk_addr_2=7 -> byp_hit_2=0 (with macro off: hits 0).
- Simultaneous push/pop at count=2 for 6 cycles -> count stays 2, pointers wrap past DEPTH, write order equals push order.
- Reset mid-drain: queue holding 3 entries with we=1, assert rst_s between edges -> we=0, count=0, in_ready=1 immediately; no further writes after release.
